// File: rtl/mdu_pkg.sv
// Shared MDU definitions: opcode and state encodings plus latency defaults.
package mdu_pkg;

    typedef enum logic [4:0] {
        MDU_NONE = 5'd0,
        MULT     = 5'd1,
        MULTU    = 5'd2,
        DIV      = 5'd3,
        DIVU     = 5'd4,
        MTHI     = 5'd5,
        MTLO     = 5'd6,
        MFHI     = 5'd7,
        MFLO     = 5'd8
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; results are latched by mdu_ctrl at issue.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz
);

    mdu_op_e            op_e;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic               b_zero;
    logic               s_ovf;

    assign op_e   = mdu_op_e'(op);
    assign b_zero = (b == '0);
    // INT_MIN / -1 overflows; pin it to quotient INT_MIN, remainder 0
    assign s_ovf  = (a == 32'h8000_0000) && (b == '1);

    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};
        quo_s  = '0;
        rem_s  = '0;
        if (!b_zero && !s_ovf) begin
            quo_s = $signed(a) / $signed(b);
            rem_s = $signed(a) % $signed(b);
        end else if (s_ovf) begin
            quo_s = $signed(a);
        end
    end

    always_comb begin
        hi = '0;
        lo = '0;
        dz = 1'b0;
        case (op_e)
            MULT:  begin hi = prod_s[63:32]; lo = prod_s[31:0]; end
            MULTU: begin hi = prod_u[63:32]; lo = prod_u[31:0]; end
            DIV: begin
                dz = b_zero;
                hi = rem_s;
                lo = quo_s;
            end
            DIVU: begin
                dz = b_zero;
                if (!b_zero) begin
                    hi = a % b;
                    lo = a / b;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: issues mult/div, counts latency, commits HI/LO, handles MTHI/MTLO.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [4:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_md,
    output logic        busy,
    output logic        stall_d,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wd,
    output logic [31:0] lo_wd
);

    mdu_state_e  state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [31:0] res_hi, res_lo;
    logic        dz;

    mdu_op_e     op;
    logic        is_start;
    logic        is_mul;
    logic        issue_now;
    logic [31:0] a_hi, a_lo;
    logic        a_dz;

    assign op       = mdu_op_e'(e_op);
    assign is_start = op inside {MULT, MULTU, DIV, DIVU};
    assign is_mul   = op inside {MULT, MULTU};
    // reset gating keeps stall_d and MTxx writes quiet while reset is held
    assign issue_now = (state == IDLE) && !req && !reset && is_start;

    mdu_arith u_arith (
        .op (e_op),
        .a  (e_rs),
        .b  (e_rt),
        .hi (a_hi),
        .lo (a_lo),
        .dz (a_dz)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        busy    = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        hi_wd   = '0;
        lo_wd   = '0;
        case (state)
            IDLE: begin
                if (issue_now) begin
                    state_d = RUN;
                    cnt_d   = is_mul ? 4'(MUL_LAT) : 4'(DIV_LAT);
                end else if (!req && !reset && op == MTHI) begin
                    hi_we = 1'b1;
                    hi_wd = e_rs;
                end else if (!req && !reset && op == MTLO) begin
                    lo_we = 1'b1;
                    lo_wd = e_rs;
                end
            end
            RUN: begin
                busy  = 1'b1;
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_d = IDLE;
                    if (!dz) begin
                        hi_we = 1'b1;
                        lo_we = 1'b1;
                        hi_wd = res_hi;
                        lo_wd = res_lo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_d = d_md & (busy | issue_now);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_hi <= '0;
            res_lo <= '0;
            dz     <= 1'b0;
        end else if (issue_now) begin
            res_hi <= a_hi;
            res_lo <= a_lo;
            dz     <= a_dz;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl using immediate assertions.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req;
    logic [4:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_md;
    logic        busy;
    logic        stall_d;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wd;
    logic [31:0] lo_wd;

    int tests;
    int fails;

    mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .e_op    (e_op),
        .e_rs    (e_rs),
        .e_rt    (e_rt),
        .d_md    (d_md),
        .busy    (busy),
        .stall_d (stall_d),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .hi_wd   (hi_wd),
        .lo_wd   (lo_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 issues; cycles 1..lat run with MTLO parked in E to show it is ignored.
    // Returns at the start of cycle lat+1 so a following call exercises back-to-back issue.
    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input int lat, input logic commit,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int flush_at);
        e_op = op; e_rs = rs; e_rt = rt; req = 1'b0;
        @(negedge clk);
        chk({tag, "_c0_busy"}, 32'(busy), 32'd0);
        chk({tag, "_c0_stall"}, 32'(stall_d), 32'(d_md));
        chk({tag, "_c0_we"}, 32'({hi_we, lo_we}), 32'd0);
        tick();
        e_op = MTLO; e_rs = 32'hDEAD_BEEF;
        for (int c = 1; c <= lat; c++) begin
            req = (c == flush_at);
            @(negedge clk);
            chk({tag, "_run_busy"}, 32'(busy), 32'd1);
            chk({tag, "_run_stall"}, 32'(stall_d), 32'(d_md));
            if (c == lat) begin
                chk({tag, "_done_hi_we"}, 32'(hi_we), 32'(commit));
                chk({tag, "_done_lo_we"}, 32'(lo_we), 32'(commit));
                if (commit) begin
                    chk({tag, "_hi_wd"}, hi_wd, eh);
                    chk({tag, "_lo_wd"}, lo_wd, el);
                end
            end else begin
                chk({tag, "_run_we"}, 32'({hi_we, lo_we}), 32'd0);
            end
            tick();
        end
        req = 1'b0; e_op = MDU_NONE;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1; req = 1'b0; d_md = 1'b1;
        e_op = MULT; e_rs = 32'h0000_0011; e_rt = 32'h0000_0003;

        // Outputs quiet while reset is held, even with an issuable op in E
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_d), 32'd0);
        chk("rst_we", 32'({hi_we, lo_we}), 32'd0);
        chk("rst_hi_wd", hi_wd, 32'd0);
        chk("rst_lo_wd", lo_wd, 32'd0);
        e_op = MTHI;
        #1;
        chk("rst_mthi_we", 32'(hi_we), 32'd0);
        reset = 1'b0;
        d_md = 1'b0;

        // Signed multiply issued on the first edge after reset, then back-to-back ops
        run_op("mult_neg", MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, -1);
        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, -1);
        run_op("mult_nn", MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5, 1'b1, 32'h0000_0000, 32'h0000_000F, -1);

        // Signed divide with D-stage stall held
        d_md = 1'b1;
        run_op("div_stall", DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        @(negedge clk);
        chk("div_stall_c11", 32'(stall_d), 32'd0);
        chk("div_busy_c11", 32'(busy), 32'd0);
        tick();
        d_md = 1'b0;

        run_op("div_negdiv", DIV, 32'd7, 32'hFFFF_FFFE, 10, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, -1);
        run_op("divu", DIVU, 32'd100, 32'd7, 10, 1'b1, 32'd2, 32'd14, -1);
        run_op("divu_dz", DIVU, 32'd5, 32'd0, 10, 1'b0, 32'd0, 32'd0, -1);

        // MTHI / MTLO write in the same cycle; MFHI does nothing
        e_op = MTHI; e_rs = 32'h0000_1234;
        @(negedge clk);
        chk("mthi_we", 32'({hi_we, lo_we}), 32'b10);
        chk("mthi_wd", hi_wd, 32'h0000_1234);
        tick();
        e_op = MTLO; e_rs = 32'h0000_ABCD;
        @(negedge clk);
        chk("mtlo_we", 32'({hi_we, lo_we}), 32'b01);
        chk("mtlo_wd", lo_wd, 32'h0000_ABCD);
        chk("mtlo_busy", 32'(busy), 32'd0);
        tick();
        e_op = MFHI;
        @(negedge clk);
        chk("mfhi_we", 32'({hi_we, lo_we}), 32'd0);
        tick();
        chk("mfhi_busy", 32'(busy), 32'd0);

        // Flush in the issue cycle suppresses start and MTxx write
        d_md = 1'b1;
        e_op = MULTU; e_rs = 32'd9; e_rt = 32'd9; req = 1'b1;
        @(negedge clk);
        chk("flush_iss_stall", 32'(stall_d), 32'd0);
        chk("flush_iss_we", 32'({hi_we, lo_we}), 32'd0);
        tick();
        e_op = MTHI; e_rs = 32'h0000_1234;
        @(negedge clk);
        chk("flush_iss_busy", 32'(busy), 32'd0);
        chk("flush_mthi_we", 32'(hi_we), 32'd0);
        tick();
        req = 1'b0; d_md = 1'b0; e_op = MDU_NONE;

        // Flush during RUN does not disturb the in-flight multiply
        run_op("flush_run", MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 3);

        // Reset in mid-operation aborts without commit
        e_op = DIV; e_rs = 32'd50; e_rt = 32'd5;
        tick();
        e_op = MDU_NONE;
        tick();
        tick();
        tick();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_we", 32'({hi_we, lo_we}), 32'd0);
        tick();
        chk("mid_rst_busy2", 32'(busy), 32'd0);
        reset = 1'b0;
        run_op("post_rst", MULT, 32'd6, 32'd7, 5, 1'b1, 32'd0, 32'd42, -1);
        @(negedge clk);
        chk("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL use parameter MUL_LAT, default 5, for the multiply latency in cycles.
REQ-002 The block SHALL use parameter DIV_LAT, default 10, for the divide latency in cycles.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 req  in  1  exception/interrupt flush of the E-stage instruction; suppresses any issue in the same cycle.
REQ-006 e_op  in  5  MDU opcode of the E-stage instruction, encoded per the shared package.
REQ-007 e_rs  in  32  E-stage forwarded rs value.
REQ-008 e_rt  in  32  E-stage forwarded rt value.
REQ-009 d_md  in  1  D-stage instruction is MDU-class (mult/multu/div/divu/mthi/mtlo/mfhi/mflo).
REQ-010 busy  out  1  operation in flight.
REQ-011 stall_d  out  1  freeze D stage.
REQ-012 hi_we  out  1  HI write enable; one-cycle pulse.
REQ-013 lo_we  out  1  LO write enable; one-cycle pulse.
REQ-014 hi_wd  out  32  HI write data.
REQ-015 lo_wd  out  32  LO write data.

Function
REQ-016 The FSM SHALL have two states, IDLE and RUN, plus a 4-bit down-counter cnt and 32-bit result registers res_hi and res_lo.
REQ-017 Issue:
- Condition: state IDLE, ~req and e_op in {MULT, MULTU, DIV, DIVU} in cycle N.
- At edge N: latch the sub-module result into res_hi/res_lo, load cnt with MUL_LAT or DIV_LAT, and enter RUN.
REQ-018 Arithmetic:
- MULT: signed 32x32 to 64 bits, split {hi, lo}.
- MULTU: unsigned 32x32 to 64 bits.
- DIV: hi = signed remainder, lo = signed quotient; remainder sign follows the dividend.
- DIVU: unsigned remainder and quotient.
REQ-019 Divide by zero (e_rt == 0 on DIV/DIVU):
- Latency and busy SHALL be unchanged.
- The commit SHALL be suppressed, leaving HI/LO unchanged.
- A sticky flag dz SHALL be registered internally for this purpose.
REQ-020 RUN: busy SHALL be 1 in cycles N+1 through N+L; cnt SHALL decrement each cycle.
REQ-021 Completion:
- In cycle N+L (cnt == 1), hi_we = lo_we = 1 (unless dz), with hi_wd = res_hi and lo_wd = res_lo.
- At edge N+L the state returns to IDLE.
REQ-022 MTHI/MTLO in IDLE with ~req SHALL assert hi_we (resp. lo_we) combinationally in the same cycle, with data = e_rs; no state change occurs.
REQ-023 MFHI/MFLO and NONE SHALL cause no action.
REQ-024 Any e_op received while in RUN SHALL be ignored, because the D-stage stall prevents it from occurring.
REQ-025 stall_d SHALL equal d_md & (busy | issue_now), where issue_now is the REQ-017 condition evaluated combinationally.
REQ-026 req asserted during RUN SHALL NOT affect the in-flight operation, which belongs to an older instruction and SHALL still commit.
REQ-027 req with a MTHI/MTLO or start op in E SHALL suppress both the write and the issue.
REQ-028 Back-to-back issue: a start op in E in cycle N+L+1 SHALL be accepted, giving no idle bubble beyond REQ-021.
REQ-029 Outputs hi_we and lo_we SHALL never be asserted simultaneously by a completion and an MTxx write.

Reset
REQ-030 Asynchronous reset SHALL force state IDLE, cnt = 0, res_hi = res_lo = 0 and dz = 0.
REQ-031 While reset is asserted, the outputs SHALL be busy = 0, stall_d = 0, hi_we = lo_we = 0 and hi_wd = lo_wd = 0.
REQ-032 Reset in mid-RUN SHALL abort the operation with no commit.
REQ-033 After reset deassertion, the first edge SHALL be able to accept an issue.

Structure
REQ-034 The shared package/header SHALL hold the opcode constants: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
REQ-035 The shared package/header SHALL hold the state encodings (IDLE=0, RUN=1) and the latency defaults.
REQ-036 One combinational sub-module, mdu_arith (op, a, b -> hi, lo, dz), SHALL be instantiated.
REQ-037 All sequencing and registers SHALL reside in mdu_ctrl.

Verification
REQ-038 Multiply with sign:
- Stimulus: MULT, rs=0xFFFFFFFE (-2), rt=3, at cycle 0.
- Response: busy high in cycles 1-5; hi_we/lo_we in cycle 5 with hi_wd=0xFFFFFFFF and lo_wd=0xFFFFFFFA.
REQ-039 Divide with D-stage stall:
- Stimulus: DIV, rs=-7, rt=2, with d_md=1 held.
- Response: stall_d high in cycles 0-10; commit in cycle 10 with hi_wd=0xFFFFFFFF (-1) and lo_wd=0xFFFFFFFD (-3); stall_d=0 in cycle 11.
REQ-040 Divide by zero: DIVU rs=5, rt=0 -> busy high for 10 cycles; hi_we and lo_we never asserted.
REQ-041 Flush in issue cycle: MULTU issued with req=1 in the same cycle -> busy stays 0, no write; MTHI rs=0x1234 with req=1 -> hi_we stays 0.
REQ-042 Flush during RUN: MULTU 0xFFFFFFFF x 2, then req pulsed in cycle 3 -> commit in cycle 5 regardless, with hi=1 and lo=0xFFFFFFFE.
REQ-043 Reset mid-operation: DIV issued, reset asserted asynchronously in cycle 4 -> busy drops immediately with no commit; a MULT issued right after reset completes normally.
